// File: rtl/clock_set_cu.sv
// clock_set_cu
// Control unit for setting the time on the clock datapath. It works alongside
// the hour/min/sec counters in the same way stopwatch_cu works with stopwatch_dp.
//
// A mode press copies the current time into the edit registers. Up and down
// presses then edit hour, min and sec in that order. Each further mode press
// moves to the next field. After the sec field, a one-cycle load pulse hands
// the edited time to the datapath.
//
// While editing:
//   - the datapath is told to hold its counters (o_set_en),
//   - the display is told which field is selected (o_field),
//   - the display is told when that field should be visible (o_blink).
//
// If no button is pressed for TIMEOUT_CYC cycles, the edit is abandoned
// without a load.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   i_btn_mode   debounced one-cycle pulse: enter set mode / advance field
//   i_btn_up     debounced one-cycle pulse: increment selected field
//   i_btn_down   debounced one-cycle pulse: decrement selected field
//   i_cur_hour   current hour from the datapath (0..23)
//   i_cur_min    current minute from the datapath (0..59)
//   i_cur_sec    current second from the datapath (0..59)
//   o_set_en     high while editing or committing; datapath holds its counters
//   o_load       one-cycle pulse; datapath loads o_hour/o_min/o_sec
//   o_hour       hour edit value
//   o_min        minute edit value
//   o_sec        second edit value
//   o_field      0=none, 1=hour, 2=min, 3=sec
//   o_blink      blink enable for the selected field
//
// Parameters
//   BLINK_DIV    clk cycles per o_blink half-period (>= 2)
//   TIMEOUT_CYC  idle clk cycles in a set state before abort (>= 2)

module clock_set_cu #(
  parameter int BLINK_DIV   = 50_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [4:0] i_cur_hour,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic       o_set_en,
  output logic       o_load,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_field,
  output logic       o_blink
);

  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int TO_W    = $clog2(TIMEOUT_CYC);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } StateT;

  // Registered state and outputs
  StateT              r_state;
  logic [4:0]         r_hour;
  logic [5:0]         r_min;
  logic [5:0]         r_sec;
  logic               r_setEn;
  logic               r_load;
  logic [1:0]         r_field;
  logic               r_blink;
  logic [BLINK_W-1:0] r_blinkCnt;
  logic [TO_W-1:0]    r_toCnt;

  // Next-state values
  StateT              w_stateNext;
  logic [4:0]         w_hourNext;
  logic [5:0]         w_minNext;
  logic [5:0]         w_secNext;
  logic [1:0]         w_fieldNext;
  logic               w_blinkNext;
  logic [BLINK_W-1:0] w_blinkCntNext;
  logic [TO_W-1:0]    w_toCntNext;

  // Button decode
  logic w_anyBtn;
  logic w_editUp;
  logic w_editDown;
  logic w_timeoutHit;
  logic w_nextInSet;

  // Increment with wrap to zero. An out-of-range value wraps straight to zero,
  // so a bad captured value is normalised by the first up press.
  function automatic logic [5:0] stepUp(input logic [5:0] val,
                                        input logic [5:0] maxVal);
    return (val >= maxVal) ? 6'd0 : (val + 6'd1);
  endfunction

  // Decrement with wrap to the maximum. An out-of-range value clamps to the
  // maximum, which matches "value-1, clamped to the maximum".
  function automatic logic [5:0] stepDown(input logic [5:0] val,
                                          input logic [5:0] maxVal);
    return ((val == 6'd0) || (val > maxVal)) ? maxVal : (val - 6'd1);
  endfunction

  // When up and down arrive together they cancel out: nothing is edited, but
  // the press still counts as activity. When mode arrives with an edit button,
  // mode wins; the FSM checks mode first, so the edit is dropped.
  assign w_anyBtn     = i_btn_mode | i_btn_up | i_btn_down;
  assign w_editUp     = i_btn_up & ~i_btn_down;
  assign w_editDown   = i_btn_down & ~i_btn_up;
  assign w_timeoutHit = (r_toCnt == TO_LAST) && !w_anyBtn;

  // Next-state logic and edit-register updates.
  // In RUN, mode copies the live time into the edit registers.
  // In each SET state:
  //   - mode moves to the next field,
  //   - otherwise a timeout aborts to RUN,
  //   - otherwise up/down edit the field that is selected.
  // COMMIT always lasts exactly one cycle.
  always_comb begin
    w_stateNext = r_state;
    w_hourNext  = r_hour;
    w_minNext   = r_min;
    w_secNext   = r_sec;

    case (r_state)
      RUN: begin
        if (i_btn_mode) begin
          w_stateNext = SET_HOUR;
          w_hourNext  = i_cur_hour;
          w_minNext   = i_cur_min;
          w_secNext   = i_cur_sec;
        end
      end

      SET_HOUR: begin
        if (i_btn_mode) begin
          w_stateNext = SET_MIN;
        end else if (w_timeoutHit) begin
          w_stateNext = RUN;
        end else if (w_editUp) begin
          w_hourNext = 5'(stepUp({1'b0, r_hour}, HOUR_MAX));
        end else if (w_editDown) begin
          w_hourNext = 5'(stepDown({1'b0, r_hour}, HOUR_MAX));
        end
      end

      SET_MIN: begin
        if (i_btn_mode) begin
          w_stateNext = SET_SEC;
        end else if (w_timeoutHit) begin
          w_stateNext = RUN;
        end else if (w_editUp) begin
          w_minNext = stepUp(r_min, MINSEC_MAX);
        end else if (w_editDown) begin
          w_minNext = stepDown(r_min, MINSEC_MAX);
        end
      end

      SET_SEC: begin
        if (i_btn_mode) begin
          w_stateNext = COMMIT;
        end else if (w_timeoutHit) begin
          w_stateNext = RUN;
        end else if (w_editUp) begin
          w_secNext = stepUp(r_sec, MINSEC_MAX);
        end else if (w_editDown) begin
          w_secNext = stepDown(r_sec, MINSEC_MAX);
        end
      end

      COMMIT: begin
        w_stateNext = RUN;
      end

      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  assign w_nextInSet = (w_stateNext == SET_HOUR) ||
                       (w_stateNext == SET_MIN)  ||
                       (w_stateNext == SET_SEC);

  // Blink, timeout and field select are computed from the state we are about
  // to enter, so the registered outputs line up with that state.
  //
  // Blink restarts solid in two cases:
  //   - on entry to any SET state,
  //   - on any edit press, so the user sees the new value at once.
  // Outside these cases it toggles every BLINK_DIV cycles.
  //
  // The timeout counter clears on any button press. Entering SET_HOUR always
  // involves a mode press, so entry clears it too.
  always_comb begin
    w_blinkCntNext = '0;
    w_blinkNext    = 1'b0;
    w_toCntNext    = '0;
    w_fieldNext    = 2'd0;

    if (w_nextInSet) begin
      if ((w_stateNext != r_state) || i_btn_up || i_btn_down) begin
        w_blinkCntNext = '0;
        w_blinkNext    = 1'b1;
      end else if (r_blinkCnt == BLINK_LAST) begin
        w_blinkCntNext = '0;
        w_blinkNext    = ~r_blink;
      end else begin
        w_blinkCntNext = r_blinkCnt + BLINK_W'(1);
        w_blinkNext    = r_blink;
      end

      if (w_anyBtn) begin
        w_toCntNext = '0;
      end else begin
        w_toCntNext = r_toCnt + TO_W'(1);
      end
    end

    case (w_stateNext)
      SET_HOUR: w_fieldNext = 2'd1;
      SET_MIN:  w_fieldNext = 2'd2;
      SET_SEC:  w_fieldNext = 2'd3;
      default:  w_fieldNext = 2'd0;
    endcase
  end

  // State and output registers.
  // Reset drops straight back to RUN with every output cleared, even in the
  // middle of an edit, so no load can leak out of an interrupted sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_setEn    <= 1'b0;
      r_load     <= 1'b0;
      r_field    <= 2'd0;
      r_blink    <= 1'b0;
      r_blinkCnt <= '0;
      r_toCnt    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_hour     <= w_hourNext;
      r_min      <= w_minNext;
      r_sec      <= w_secNext;
      r_setEn    <= (w_stateNext != RUN);
      r_load     <= (w_stateNext == COMMIT);
      r_field    <= w_fieldNext;
      r_blink    <= w_blinkNext;
      r_blinkCnt <= w_blinkCntNext;
      r_toCnt    <= w_toCntNext;
    end
  end

  assign o_set_en = r_setEn;
  assign o_load   = r_load;
  assign o_hour   = r_hour;
  assign o_min    = r_min;
  assign o_sec    = r_sec;
  assign o_field  = r_field;
  assign o_blink  = r_blink;

endmodule

// File: tb/tb_clock_set_cu.sv
// tb_clock_set_cu
// Directed testbench for clock_set_cu, built with BLINK_DIV=4 and TIMEOUT_CYC=20.
// Inputs are driven and outputs are sampled on the falling clock edge.

module tb_clock_set_cu;

  logic       clk;
  logic       rst;
  logic       btnMode;
  logic       btnUp;
  logic       btnDown;
  logic [4:0] curHour;
  logic [5:0] curMin;
  logic [5:0] curSec;
  logic       setEn;
  logic       load;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] sec;
  logic [1:0] field;
  logic       blink;

  int totalChecks = 0;
  int badChecks   = 0;
  int loadCount   = 0;
  int loadBase    = 0;

  // Expected blink levels for the 12 cycles after entering SET_HOUR:
  // four cycles on, four off, four on.
  logic [11:0] blinkPattern;

  clock_set_cu #(
    .BLINK_DIV  (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_btn_mode(btnMode),
    .i_btn_up  (btnUp),
    .i_btn_down(btnDown),
    .i_cur_hour(curHour),
    .i_cur_min (curMin),
    .i_cur_sec (curSec),
    .o_set_en  (setEn),
    .o_load    (load),
    .o_hour    (hour),
    .o_min     (minute),
    .o_sec     (sec),
    .o_field   (field),
    .o_blink   (blink)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which o_load is high, sampled shortly after the
  // rising edge
  always @(posedge clk) begin
    #1;
    if (load === 1'b1) loadCount++;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag, input int expSetEn,
                            input int expLoad, input int expField,
                            input int expBlink);
    checkOutput({tag, " set_en"}, 32'(setEn), 32'(expSetEn));
    checkOutput({tag, " load"},   32'(load),  32'(expLoad));
    checkOutput({tag, " field"},  32'(field), 32'(expField));
    checkOutput({tag, " blink"},  32'(blink), 32'(expBlink));
  endtask

  task automatic checkTime(input string tag, input int expHour,
                           input int expMin, input int expSec);
    checkOutput({tag, " hour"}, 32'(hour),   32'(expHour));
    checkOutput({tag, " min"},  32'(minute), 32'(expMin));
    checkOutput({tag, " sec"},  32'(sec),    32'(expSec));
  endtask

  // Present the buttons for one rising edge and return at the next falling
  // edge, where the result of that press is visible
  task automatic applyStimulus(input logic m, input logic u, input logic d);
    btnMode = m;
    btnUp   = u;
    btnDown = d;
    @(posedge clk);
    @(negedge clk);
    btnMode = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    blinkPattern = 12'b1111_0000_1111;
    rst     = 1'b1;
    btnMode = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
    curHour = 5'd0;
    curMin  = 6'd0;
    curSec  = 6'd0;
    repeat (2) @(negedge clk);
    checkState("reset", 0, 0, 0, 0);
    checkTime("reset", 0, 0, 0);
    rst = 1'b0;
    idleCycles(1);
    checkState("idle run", 0, 0, 0, 0);

    // Full set sequence: 12:34:56 edited to 15:32:57
    $display("[TB] full set sequence");
    curHour = 5'd12; curMin = 6'd34; curSec = 6'd56;
    loadBase = loadCount;
    applyStimulus(1, 0, 0);
    checkState("t1 enter", 1, 0, 1, 1);
    checkTime("t1 capture", 12, 34, 56);
    repeat (3) applyStimulus(0, 1, 0);
    checkTime("t1 hour up", 15, 34, 56);
    applyStimulus(1, 0, 0);
    checkState("t1 min field", 1, 0, 2, 1);
    repeat (2) applyStimulus(0, 0, 1);
    checkTime("t1 min down", 15, 32, 56);
    applyStimulus(1, 0, 0);
    checkState("t1 sec field", 1, 0, 3, 1);
    applyStimulus(0, 1, 0);
    checkTime("t1 sec up", 15, 32, 57);
    applyStimulus(1, 0, 0);
    checkState("t1 commit", 1, 1, 0, 0);
    checkTime("t1 commit", 15, 32, 57);
    idleCycles(1);
    checkState("t1 back to run", 0, 0, 0, 0);
    checkOutput("t1 load count", 32'(loadCount - loadBase), 32'd1);

    // Wrap boundaries
    $display("[TB] wrap boundaries");
    curHour = 5'd23; curMin = 6'd59; curSec = 6'd0;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkTime("t2 hour wrap up", 0, 59, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkTime("t2 min wrap up", 0, 0, 0);
    applyStimulus(0, 0, 1);
    checkTime("t2 min wrap down", 0, 59, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    checkTime("t2 sec wrap down", 0, 59, 59);
    applyStimulus(1, 0, 0);
    checkState("t2 commit", 1, 1, 0, 0);
    checkTime("t2 commit", 0, 59, 59);
    idleCycles(1);

    // Simultaneous button events
    $display("[TB] simultaneous events");
    applyStimulus(1, 0, 0);
    idleCycles(10);
    applyStimulus(0, 1, 1);
    checkTime("t3 up+down", 23, 59, 0);
    idleCycles(15);
    checkOutput("t3 timeout cleared set_en", 32'(setEn), 32'd1);
    checkOutput("t3 timeout cleared field", 32'(field), 32'd1);
    applyStimulus(1, 1, 0);
    checkOutput("t3 mode+up field", 32'(field), 32'd2);
    checkOutput("t3 mode+up hour", 32'(hour), 32'd23);
    idleCycles(20);
    checkState("t3 timed out", 0, 0, 0, 0);
    applyStimulus(0, 1, 0);
    checkState("t3 up in run", 0, 0, 0, 0);
    checkOutput("t3 up in run hour", 32'(hour), 32'd23);

    // Timeout window
    $display("[TB] timeout");
    curHour = 5'd1; curMin = 6'd2; curSec = 6'd3;
    loadBase = loadCount;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    idleCycles(19);
    checkOutput("t4 still set_en", 32'(setEn), 32'd1);
    checkOutput("t4 still field", 32'(field), 32'd2);
    idleCycles(1);
    checkState("t4 expired", 0, 0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    idleCycles(19);
    applyStimulus(0, 1, 1);
    checkOutput("t4 late press set_en", 32'(setEn), 32'd1);
    idleCycles(19);
    checkOutput("t4 restarted window", 32'(setEn), 32'd1);
    idleCycles(1);
    checkState("t4 expired again", 0, 0, 0, 0);
    checkOutput("t4 no load", 32'(loadCount - loadBase), 32'd0);

    // Blink cadence
    $display("[TB] blink");
    curHour = 5'd8; curMin = 6'd0; curSec = 6'd0;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("t5 blink cadence", 32'(blink), 32'(blinkPattern[11-i]));
      idleCycles(1);
    end
    idleCycles(1);
    checkOutput("t5 low phase", 32'(blink), 32'd0);
    applyStimulus(0, 1, 0);
    checkOutput("t5 hour after up", 32'(hour), 32'd9);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5 solid after up", 32'(blink), 32'd1);
      idleCycles(1);
    end
    checkOutput("t5 low after restart", 32'(blink), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkState("t5 commit", 1, 1, 0, 0);
    checkTime("t5 commit", 9, 0, 0);
    idleCycles(1);
    checkOutput("t5 blink in run", 32'(blink), 32'd0);

    // Out-of-range capture is normalised by the first edit
    $display("[TB] out-of-range capture");
    curHour = 5'd30; curMin = 6'd62; curSec = 6'd0;
    applyStimulus(1, 0, 0);
    checkTime("t7 capture as-is", 30, 62, 0);
    applyStimulus(0, 0, 1);
    checkOutput("t7 hour clamp down", 32'(hour), 32'd23);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t7 min up normalise", 32'(minute), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkState("t7 commit", 1, 1, 0, 0);
    checkTime("t7 commit", 23, 0, 0);
    idleCycles(1);

    // Asynchronous reset in the middle of an edit
    $display("[TB] async reset");
    curHour = 5'd10; curMin = 6'd20; curSec = 6'd30;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("t6 in set_sec", 32'(field), 32'd3);
    loadBase = loadCount;
    #2 rst = 1'b1;
    #1;
    checkState("t6 async", 0, 0, 0, 0);
    checkTime("t6 async", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6 no load", 32'(loadCount - loadBase), 32'd0);
    curHour = 5'd5; curMin = 6'd6; curSec = 6'd7;
    applyStimulus(1, 0, 0);
    checkState("t6 re-enter", 1, 0, 1, 1);
    checkTime("t6 fresh capture", 5, 6, 7);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/clock_set_cu.md
Name: clock_set_cu

Overview:
- Control unit that sequences time-setting of the clock datapath (hour/min/sec counters beside stopwatch_dp).
- Snapshots the current time, lets the user edit hour, then min, then sec with up/down buttons, then issues a one-cycle load pulse.
- Halts the datapath while editing and drives field-select and blink signals for the display.
- Sits between the debounced button pulses and the clock datapath, in the same role stopwatch_cu plays for stopwatch_dp.

Parameters:
- BLINK_DIV, 50_000_000: clk cycles per o_blink half-period (≥2).
- TIMEOUT_CYC, 500_000_000: idle clk cycles in any SET state before abort (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- i_btn_mode  input  1  debounced single-cycle pulse: enter set / advance field
- i_btn_up  input  1  debounced single-cycle pulse: increment selected field
- i_btn_down  input  1  debounced single-cycle pulse: decrement selected field
- i_cur_hour  input  5  current hour from datapath, 0..23
- i_cur_min  input  6  current min from datapath, 0..59
- i_cur_sec  input  6  current sec from datapath, 0..59
- o_set_en  output  1  high in any SET/COMMIT state; datapath must hold its counters
- o_load  output  1  one-cycle pulse; datapath loads o_hour/o_min/o_sec
- o_hour  output  5  edit value for hour
- o_min  output  6  edit value for min
- o_sec  output  6  edit value for sec
- o_field  output  2  0=none, 1=hour, 2=min, 3=sec
- o_blink  output  1  display blink enable for the selected field

Behaviour:
- Reset (async, rst=1):
  - State RUN.
  - o_set_en=0, o_load=0, o_hour=o_min=o_sec=0, o_field=0, o_blink=0.
  - Blink and timeout counters cleared.
- All outputs are registered. A button pulse in cycle N produces its effect in cycle N+1.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN:
  - o_set_en=0, o_field=0, o_blink=0.
  - up/down are ignored.
  - mode → SET_HOUR; the edit registers capture i_cur_hour/min/sec in the same edge.
- SET_HOUR --mode--> SET_MIN --mode--> SET_SEC --mode--> COMMIT.
- COMMIT:
  - Lasts exactly one cycle with o_load=1 and o_set_en=1, then RUN.
  - Buttons arriving during COMMIT are ignored.
- Editing (SET states only; applies to the selected field):
  - up: +1 with wrap. Hour 23→0; min/sec 59→0.
  - down: −1 with wrap. Hour 0→23; min/sec 0→59.
  - up and down in the same cycle: no change. This still counts as activity and resets the timeout.
  - mode together with up/down in the same cycle: mode wins, the edit is dropped.
- o_field: 1/2/3 in SET_HOUR/SET_MIN/SET_SEC; 0 in RUN and COMMIT.
- Blink:
  - In SET states, a counter runs from 0 to BLINK_DIV−1; at terminal count o_blink toggles and the counter restarts.
  - On entry to any SET state and on any up/down pulse, the counter clears and o_blink=1, so an edited value is shown solid immediately.
  - o_blink=0 in RUN and COMMIT.
- Timeout:
  - Counter runs only in SET states.
  - Cleared on any button pulse and on entering SET_HOUR.
  - On reaching TIMEOUT_CYC−1 with no button in that cycle: go to RUN, no o_load, edits discarded.
  - The datapath resumes with its held values.
- Edit registers retain their last values in RUN; they are meaningful only while o_set_en=1.
- Input range: i_cur_* values outside range are captured as-is. The first up/down normalises them (hour >23 with up → 0; down → value−1 clamped to 23; same rule for min/sec against 59).
- Reset mid-edit: immediate return to RUN, no load pulse, outputs at reset values.
- o_load is never asserted more than one cycle per set sequence and never outside COMMIT.

Test Plan:
(Bench uses BLINK_DIV=4, TIMEOUT_CYC=20.)
1. Full set sequence:
   - Stimulus: cur=12:34:56; mode; up×3 (hour 15); mode; down×2 (min 32); mode; up (sec 57); mode.
   - Response: o_set_en high from the cycle after the first mode; o_field steps 1,2,3.
   - Response: one-cycle o_load with 15:32:57, then RUN with o_set_en=0.
2. Wrap boundaries:
   - Hour: cur=23:59:00; up in SET_HOUR → 0.
   - Min: up in SET_MIN → 0; down → 59.
   - Sec: sec=0, down in SET_SEC → 59.
3. Simultaneous events:
   - up+down same cycle → value unchanged, timeout cleared.
   - mode+up in SET_HOUR → field advances to 2, hour unchanged.
   - up in RUN → no state or output change.
4. Timeout:
   - Stimulus: enter SET_MIN, then no buttons for 20 cycles.
   - Response: returns to RUN, o_load never asserted, o_field=0.
   - Response: a button at cycle 19 instead restarts the 20-cycle window.
5. Blink:
   - In SET_HOUR, o_blink=1 for 4 cycles, 0 for 4, 1 for 4, and so on.
   - An up pulse mid-low phase forces o_blink=1 the next cycle and restarts the 4-cycle phase.
   - o_blink=0 in RUN.
6. Async reset mid-edit:
   - Stimulus: assert rst between clock edges during SET_SEC.
   - Response: all outputs 0 immediately, without waiting for a clock edge; no o_load.
   - Response: after release, one mode pulse re-enters SET_HOUR with a fresh capture.
